// File: rtl/snn_img_sender.sv
// Streams a 1-bit image to the classifier over UART, eight pixels per byte (LSB = lowest pixel),
// then waits for the ASCII digit reply or a timeout and reports the result.
module snn_img_sender #(
    parameter int          NUM_BYTES   = 98,
    parameter logic [23:0] RSP_TIMEOUT = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [9:0] img_addr,
    input  logic       img_q,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit,
    output logic       err
);

    // state    | meaning
    // IDLE     | waiting for start
    // FETCH    | 8 pixel reads + 1 read-latency cycle into sr
    // SEND     | latch sr into tx_data, pulse trmt
    // WAIT_TX  | wait for tx_done, then next byte or response
    // WAIT_RSP | wait for result byte, timeout counter running
    // FIN      | decode result, pulse done
    typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_TX, WAIT_RSP, FIN} state_t;

    localparam int              BW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BW-1:0]   LAST_BYTE = BW'(NUM_BYTES - 1);
    localparam logic [23:0]     TMO_LAST  = RSP_TIMEOUT - 24'd1;

    state_t        state_q, state_d;
    logic [BW-1:0] byte_q, byte_d, byte_inc;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic [23:0]   tmo_q, tmo_d, tmo_nxt;
    logic [7:0]    rsp_q, rsp_d;
    logic [9:0]    img_addr_q, img_addr_d;
    logic          trmt_q, trmt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    digit_q, digit_d;
    logic          err_q, err_d;

    assign byte_inc = byte_q + BW'(1);
    assign tmo_nxt  = tmo_q + 24'd1;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        tmo_d      = tmo_q;
        rsp_d      = rsp_q;
        img_addr_d = img_addr_q;
        trmt_d     = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        digit_d    = digit_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    byte_d     = '0;
                    bit_d      = 4'd0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    img_addr_d = 10'd0;
                end
            end
            FETCH: begin
                bit_d = bit_q + 4'd1;
                // Data for the address issued last cycle arrives now, so skip the first cycle.
                if (bit_q != 4'd0) sr_d = {img_q, sr_q[7:1]};
                if (bit_q < 4'd7) img_addr_d = 10'({byte_q, 3'b000}) + 10'(bit_q + 4'd1);
                else              img_addr_d = 10'd0;
                if (bit_q == 4'd8) begin
                    bit_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_data_d = sr_q;
                trmt_d    = 1'b1;
                state_d   = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (byte_q == LAST_BYTE) begin
                        tmo_d   = 24'd0;
                        state_d = WAIT_RSP;
                    end else begin
                        byte_d     = byte_inc;
                        bit_d      = 4'd0;
                        img_addr_d = 10'({byte_inc, 3'b000});
                        state_d    = FETCH;
                    end
                end
            end
            WAIT_RSP: begin
                tmo_d = tmo_nxt;
                if (rx_rdy) begin
                    rsp_d   = rx_data;
                    state_d = FIN;
                end else if (tmo_nxt == TMO_LAST) begin
                    // A non-digit code makes FIN report the timeout as an error.
                    rsp_d   = 8'hFF;
                    state_d = FIN;
                end
            end
            FIN: begin
                if (rsp_q >= 8'h30 && rsp_q <= 8'h39) begin
                    digit_d = rsp_q[3:0];
                end else begin
                    digit_d = 4'hF;
                    err_d   = 1'b1;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            bit_q      <= 4'd0;
            sr_q       <= 8'h00;
            tmo_q      <= 24'd0;
            rsp_q      <= 8'h00;
            img_addr_q <= 10'd0;
            trmt_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            digit_q    <= 4'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            tmo_q      <= tmo_d;
            rsp_q      <= rsp_d;
            img_addr_q <= img_addr_d;
            trmt_q     <= trmt_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            digit_q    <= digit_d;
            err_q      <= err_d;
        end
    end

    assign img_addr = img_addr_q;
    assign trmt     = trmt_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign digit    = digit_q;
    assign err      = err_q;

endmodule

// File: tb/tb_snn_img_sender.sv
// Bench for snn_img_sender: random images and replies checked against a pixel-to-byte model,
// with a UART transmitter/receiver stand-in and a synchronous 1-bit image memory.
`timescale 1ns/1ps
module tb_snn_img_sender;
    localparam int NB     = 98;
    localparam int NPIX   = NB * 8;
    localparam int TMO    = 100;
    localparam int TX_LAT = 20;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [9:0] img_addr;
    logic       img_q    = 1'b0;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done  = 1'b0;
    logic       rx_rdy   = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       busy, done;
    logic [3:0] digit;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mem [0:NPIX-1];
    logic [7:0] sent [$];
    int trmt_cycs [$];
    int frame_base = 0;
    int spur_at = -1;
    int rsp_en = 0;
    logic [7:0] rsp_byte = 8'h00;
    int rsp_delay = 0;
    int last_txd_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int stable_bad = 0;
    int width_bad = 0;
    int addr_bad = 0;
    logic [7:0] resp_b;
    int aborted;
    logic [3:0] exp_digit = 4'h0;
    logic       exp_err = 1'b0;

    snn_img_sender #(.NUM_BYTES(NB), .RSP_TIMEOUT(24'(TMO))) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_addr(img_addr), .img_q(img_q),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .rx_rdy(rx_rdy),
        .rx_data(rx_data), .busy(busy), .done(done), .digit(digit), .err(err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) img_q <= (img_addr < 10'(NPIX)) ? mem[img_addr] : 1'b0;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (img_addr >= 10'(NPIX) || (!busy && img_addr != 10'd0) || (trmt && img_addr != 10'd0))
            addr_bad <= addr_bad + 1;
    end

    // UART stand-in: takes each trmt, returns tx_done TX_LAT cycles later, and answers the last byte.
    initial begin
        forever begin
            @(negedge clk);
            if (trmt && rst_n) begin
                resp_b = tx_data;
                sent.push_back(resp_b);
                trmt_cycs.push_back(cyc);
                aborted = 0;
                for (int k = 0; k < TX_LAT; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1;
                        rx_rdy = 1'b0;
                        break;
                    end
                    if (k == 0 && trmt) width_bad++;
                    if (tx_data !== resp_b) stable_bad++;
                    rx_rdy = (k == 5 && spur_at == int'(sent.size()) - 1);
                    if (rx_rdy) rx_data = 8'h35;
                end
                if (aborted == 0) begin
                    rx_rdy = 1'b0;
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                    last_txd_cyc = cyc;
                    if (rsp_en != 0 && int'(sent.size()) - frame_base == NB) begin
                        for (int k = 0; k < rsp_delay; k++) @(negedge clk);
                        rx_data = rsp_byte;
                        rx_rdy = 1'b1;
                        @(negedge clk);
                        rx_rdy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_image(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            if (mode == 0)      mem[i] = 1'b1;
            else if (mode == 1) mem[i] = (i == 9);
            else                mem[i] = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic logic [7:0] model_byte(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = mem[8 * k + i];
        return b;
    endfunction

    task automatic pulse_start(output int start_cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_frame(input string tag, input int mode, input int r_en, input logic [7:0] r_byte,
                             input int r_delay, input int spur, input int extra_start);
        int start_cyc, d0, ok, fired;
        logic [3:0] e_digit;
        logic e_err;
        load_image(mode);
        check({tag, "_held_digit"}, 32'(digit), 32'(exp_digit));
        check({tag, "_held_err"}, 32'(err), 32'(exp_err));
        frame_base = sent.size();
        spur_at = (spur >= 0) ? frame_base + spur : -1;
        rsp_en = r_en;
        rsp_byte = r_byte;
        rsp_delay = r_delay;
        d0 = done_cnt;
        pulse_start(start_cyc);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_err_clr"}, 32'(err), 32'd0);
        ok = 0;
        fired = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
            if (extra_start >= 0 && fired == 0 && int'(sent.size()) - frame_base == extra_start + 1) begin
                start = 1'b1;
                fired = 1;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_nbytes"}, 32'(int'(sent.size()) - frame_base), 32'(NB));
        if (int'(sent.size()) - frame_base >= NB) begin
            for (int k = 0; k < NB; k++) check({tag, "_byte"}, 32'(sent[frame_base + k]), 32'(model_byte(k)));
            check({tag, "_first_trmt"}, 32'(trmt_cycs[frame_base] - start_cyc), 32'd10);
        end
        if (r_en != 0 && r_delay <= TMO - 2 && r_byte >= 8'h30 && r_byte <= 8'h39) begin
            e_digit = 4'(r_byte - 8'h30);
            e_err = 1'b0;
        end else begin
            e_digit = 4'hF;
            e_err = 1'b1;
        end
        if (r_en == 0 || r_delay > TMO - 2)
            check({tag, "_tmo_latency"}, 32'(done_cyc - last_txd_cyc), 32'(TMO));
        check({tag, "_digit"}, 32'(digit), 32'(e_digit));
        check({tag, "_err"}, 32'(err), 32'(e_err));
        exp_digit = e_digit;
        exp_err = e_err;
        spur_at = -1;
        rsp_en = 0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int sc, d0, n0, ok;
        load_image(2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trmt", 32'(trmt), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_img_addr", 32'(img_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_digit", 32'(digit), 32'h0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_frame("ones", 0, 1, 8'h37, 20, -1, -1);
        run_frame("pix9", 1, 1, 8'h32, 5, -1, -1);
        check("pix9_byte0", 32'(sent[sent.size() - NB]), 32'h00);
        check("pix9_byte1", 32'(sent[sent.size() - NB + 1]), 32'h02);
        run_frame("tmo", 2, 0, 8'h00, 0, -1, -1);
        run_frame("bad_rsp", 2, 1, 8'h41, int'($urandom_range(0, 60)), 30, -1);
        run_frame("start40", 2, 1, 8'(8'h30 + $urandom_range(0, 9)), int'($urandom_range(0, 60)), -1, 40);
        run_frame("edge_rx", 2, 1, 8'h33, TMO - 2, -1, -1);
        run_frame("late_rx", 2, 1, 8'h39, TMO - 1, -1, -1);

        // Reset in the middle of byte 50: frame abandoned, no further traffic until a new start.
        load_image(2);
        frame_base = sent.size();
        d0 = done_cnt;
        pulse_start(sc);
        ok = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (int'(sent.size()) - frame_base >= 51) begin
                ok = 1;
                break;
            end
        end
        check("rst_mid_reach50", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_trmt", 32'(trmt), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h00);
        check("mid_rst_img_addr", 32'(img_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_digit", 32'(digit), 32'h0);
        check("mid_rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n0 = sent.size();
        repeat (300) @(negedge clk);
        check("post_rst_no_trmt", 32'(sent.size()), 32'(n0));
        check("post_rst_no_done", 32'(done_cnt), 32'(d0));
        check("post_rst_busy", 32'(busy), 32'd0);
        exp_digit = 4'h0;
        exp_err = 1'b0;
        run_frame("post_rst", 2, 1, 8'(8'h30 + $urandom_range(0, 9)), int'($urandom_range(0, 60)), -1, -1);

        check("tx_data_stable", 32'(stable_bad), 32'd0);
        check("trmt_width", 32'(width_bad), 32'd0);
        check("img_addr_range", 32'(addr_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
